// File: rtl/tlc_timing_pkg.sv
// Shared timing constants and helpers for the traffic light controller.
package tlc_timing_pkg;

   localparam int CLK_HZ_DEF  = 100_000_000;
   localparam int BASE_HZ_DEF = 1000;

   // Standard per-channel divisors against a 1 kHz base tick.
   localparam int DIV_1HZ   = 1000;
   localparam int DIV_BLINK = 500;

   function automatic int clog2_min1(input int v);
      return ($clog2(v) < 1) ? 1 : $clog2(v);
   endfunction

endpackage

// File: rtl/tick_channel.sv
// One output channel: divides the base tick by a programmable divisor.
module tick_channel import tlc_timing_pkg::*; #(
   parameter int DIV_W    = 16,
   parameter int DIV_INIT = DIV_1HZ
) (
   input  logic             clk,
   input  logic             Sync_Reset,
   input  logic             step,
   input  logic             realign,
   input  logic             wr,
   input  logic [DIV_W-1:0] wdata,
   output logic             tick,
   output logic             square
);

   logic [DIV_W-1:0] div, cnt, pend;
   logic             pend_v;

   always_ff @(posedge clk) begin
      if (Sync_Reset) begin
         div    <= DIV_W'(DIV_INIT);
         cnt    <= '0;
         pend   <= '0;
         pend_v <= 1'b0;
         tick   <= 1'b0;
         square <= 1'b1;
      end else begin
         if (realign) begin
            cnt    <= '0;
            tick   <= 1'b0;
            square <= 1'b1;
         end else if (step) begin
            if (cnt == div - DIV_W'(1)) begin
               cnt    <= '0;
               tick   <= 1'b1;
               square <= ~square;
               if (pend_v) begin
                  div    <= pend;
                  pend_v <= 1'b0;
               end
            end else begin
               cnt  <= cnt + DIV_W'(1);
               tick <= 1'b0;
            end
         end else begin
            tick <= 1'b0;
         end
         // Placed after the wrap so a same-edge write stays pending for the next wrap.
         if (wr) begin
            pend   <= wdata;
            pend_v <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/tick_divider.sv
// Multi-channel tick generator: common prescaler to BASE_HZ, then a
// programmable divider per channel producing a strobe and a square wave.
module tick_divider import tlc_timing_pkg::*; #(
   parameter int CLK_HZ   = CLK_HZ_DEF,
   parameter int BASE_HZ  = BASE_HZ_DEF,
   parameter int NUM_CH   = 4,
   parameter int DIV_W    = 16,
   parameter int DIV_INIT = DIV_1HZ
) (
   input  logic                          clk,
   input  logic                          Sync_Reset,
   input  logic                          en,
   input  logic                          realign,
   input  logic                          cfg_we,
   input  logic [clog2_min1(NUM_CH)-1:0] cfg_ch,
   input  logic [DIV_W-1:0]              cfg_div,
   output logic                          base_tick,
   output logic [NUM_CH-1:0]             tick,
   output logic [NUM_CH-1:0]             square,
   output logic                          cfg_err
);

   localparam int PRE_MAX = CLK_HZ / BASE_HZ - 1;
   localparam int PRE_W   = clog2_min1(PRE_MAX + 1);
   localparam int CH_W    = clog2_min1(NUM_CH);

   generate
      if (CLK_HZ % BASE_HZ != 0) begin : g_bad_ratio
         $error("tick_divider: CLK_HZ must be a multiple of BASE_HZ");
      end
      if (NUM_CH < 1) begin : g_bad_nch
         $error("tick_divider: NUM_CH must be at least 1");
      end
      if (DIV_INIT < 1 || DIV_INIT > (2 ** DIV_W) - 1) begin : g_bad_init
         $error("tick_divider: DIV_INIT out of range");
      end
   endgenerate

   logic [PRE_W-1:0] pre;
   logic             cfg_ok;
   logic             step;

   always_ff @(posedge clk) begin
      if (Sync_Reset || realign) begin
         pre       <= '0;
         base_tick <= 1'b0;
      end else if (en) begin
         if (pre == PRE_W'(PRE_MAX)) begin
            pre       <= '0;
            base_tick <= 1'b1;
         end else begin
            pre       <= pre + PRE_W'(1);
            base_tick <= 1'b0;
         end
      end else begin
         base_tick <= 1'b0;
      end
   end

   // A zero divisor or a channel index beyond NUM_CH is rejected outright.
   assign cfg_ok = (cfg_div != '0) && (int'(cfg_ch) < NUM_CH);

   always_ff @(posedge clk) begin
      if (Sync_Reset) cfg_err <= 1'b0;
      else            cfg_err <= cfg_we && !cfg_ok;
   end

   // Channels consume the registered base tick only while counting is enabled.
   assign step = base_tick && en;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      tick_channel #(
         .DIV_W    (DIV_W),
         .DIV_INIT (DIV_INIT)
      ) u_ch (
         .clk        (clk),
         .Sync_Reset (Sync_Reset),
         .step       (step),
         .realign    (realign),
         .wr         (cfg_we && cfg_ok && (cfg_ch == CH_W'(g))),
         .wdata      (cfg_div),
         .tick       (tick[g]),
         .square     (square[g])
      );
   end

endmodule
